// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 16-register pipelined cpu: widths,
// the memory-stage FSM encoding and the writeback bundle.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // Writeback bundle seen by the register file and the commit trace.
    typedef struct packed {
        logic              regwrt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              hlt;
    } wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_wb_stage_if;
    import cpu_pkg::*;

    // Handshake: the master holds mem_req/mem_we/mem_addr/mem_wdata stable
    // from the first cycle mem_req is high until the slave answers with a
    // single-cycle mem_ack; mem_rdata is meaningful only in that ack cycle.
    // The access completes in the ack cycle and a new request may start on
    // the very next cycle. mem_ack without mem_req is ignored.
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the new bundle on unstalled edges, a
// bubble while stalled, and keeps the halt flag sticky until reset.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              regwrtIn,
    input  logic [REG_W-1:0]  rdIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              hltIn,
    output wb_t               wbQ
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbQ <= '0;
        end else if (stall) begin
            // Bubble: rd/data keep their old contents, only the write is killed.
            wbQ.regwrt <= 1'b0;
        end else begin
            wbQ.regwrt <= regwrtIn & ~wbQ.hlt;
            wbQ.rd     <= rdIn;
            wbQ.data   <= dataIn;
            wbQ.hlt    <= wbQ.hlt | hltIn;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: issues data-memory requests,
// stalls upstream while an access is outstanding, and flags ack timeouts.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 255
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_ex,
    input  logic              memrd_ex,
    input  logic              memwr_ex,
    input  logic              regwrt_ex,
    input  logic [REG_W-1:0]  rd_ex,
    input  logic [DATA_W-1:0] alu_ex,
    input  logic [DATA_W-1:0] stdata_ex,
    input  logic              hlt_ex,
    mem_wb_stage_if.master    memBus,
    output logic              stall_mem,
    output logic [DATA_W-1:0] fwd_mem,
    output logic              regwrt_wb,
    output logic [REG_W-1:0]  rd_wb,
    output logic [DATA_W-1:0] wbdata_wb,
    output logic              hlt_wb,
    output logic              mem_err,
    output memState_t         dbgState
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    memState_t   state;
    memState_t   nextState;
    logic        memInstr;
    logic        memReq;
    logic        stall;
    logic        reqOut;
    logic [7:0]  waitCnt;
    logic        errQ;
    wb_t         wbQ;

    // After a halt commits, memory instructions are treated as dead.
    assign memInstr = valid_ex & (memrd_ex | memwr_ex) & ~wbQ.hlt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                memReq = memInstr;
                stall  = memInstr & ~memBus.mem_ack;
                if (memInstr && !memBus.mem_ack) nextState = WAIT;
            end
            WAIT: begin
                memReq = 1'b1;
                stall  = ~memBus.mem_ack;
                if (memBus.mem_ack) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Counter saturates at MAX_CNT so the error flag stays set while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= 8'd0;
            errQ    <= 1'b0;
        end else if (state == WAIT && !memBus.mem_ack) begin
            if (waitCnt != MAX_CNT)           waitCnt <= waitCnt + 8'd1;
            if (waitCnt >= MAX_CNT - 8'd1)    errQ    <= 1'b1;
        end else begin
            waitCnt <= 8'd0;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .regwrtIn (valid_ex & regwrt_ex & ~memwr_ex),
        .rdIn     (rd_ex),
        .dataIn   ((valid_ex & memrd_ex) ? memBus.mem_rdata : alu_ex),
        .hltIn    (valid_ex & hlt_ex),
        .wbQ      (wbQ)
    );

    // Combinational outputs are forced low while reset is asserted so the
    // request drops in the same cycle rst_n falls.
    assign reqOut           = rst_n & memReq;
    assign memBus.mem_req   = reqOut;
    assign memBus.mem_we    = reqOut & memwr_ex;
    assign memBus.mem_addr  = reqOut ? alu_ex    : '0;
    assign memBus.mem_wdata = reqOut ? stdata_ex : '0;
    assign stall_mem        = rst_n & stall;
    assign fwd_mem          = rst_n ? alu_ex : '0;

    assign regwrt_wb = wbQ.regwrt;
    assign rd_wb     = wbQ.rd;
    assign wbdata_wb = wbQ.data;
    assign hlt_wb    = wbQ.hlt;
    assign mem_err   = errQ;
    assign dbgState  = state;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU, load/store with waits, reset
// mid-access, ack timeout and halt behaviour.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              valid_ex, memrd_ex, memwr_ex, regwrt_ex, hlt_ex;
    logic [REG_W-1:0]  rd_ex;
    logic [DATA_W-1:0] alu_ex, stdata_ex;
    logic              stall_mem, regwrt_wb, hlt_wb, mem_err;
    logic [DATA_W-1:0] fwd_mem, wbdata_wb;
    logic [REG_W-1:0]  rd_wb;
    memState_t         dbgState;
    int                tests;
    int                fails;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.MAX_WAIT(255)) dut (
        .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .memrd_ex(memrd_ex),
        .memwr_ex(memwr_ex), .regwrt_ex(regwrt_ex), .rd_ex(rd_ex), .alu_ex(alu_ex),
        .stdata_ex(stdata_ex), .hlt_ex(hlt_ex), .memBus(bus.master),
        .stall_mem(stall_mem), .fwd_mem(fwd_mem), .regwrt_wb(regwrt_wb), .rd_wb(rd_wb),
        .wbdata_wb(wbdata_wb), .hlt_wb(hlt_wb), .mem_err(mem_err), .dbgState(dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clear_ex();
        valid_ex = 0; memrd_ex = 0; memwr_ex = 0; regwrt_ex = 0; hlt_ex = 0;
        rd_ex = '0; alu_ex = '0; stdata_ex = '0;
    endtask

    task automatic drive_op(input logic rd_, input logic wr_, input logic rw_,
                            input logic [REG_W-1:0] r, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] sd);
        valid_ex = 1; memrd_ex = rd_; memwr_ex = wr_; regwrt_ex = rw_; hlt_ex = 0;
        rd_ex = r; alu_ex = a; stdata_ex = sd;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_ex(); bus.mem_ack = 0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b want 0", bus.mem_req); end
        tests++; if (stall_mem !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall_mem); end
        tests++; if ({regwrt_wb, rd_wb, wbdata_wb, hlt_wb, mem_err} !== '0) begin fails++; $display("FAIL reset_wb: got %h want 0", {regwrt_wb, rd_wb, wbdata_wb, hlt_wb, mem_err}); end
        tests++; if (dbgState !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", dbgState); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b0) begin fails++; $display("FAIL reset_release_regwrt: got %0b want 0", regwrt_wb); end
    endtask

    task automatic test_alu();
        @(negedge clk); drive_op(0, 0, 1, 4'd5, 16'h1234, 16'h0);
        #1;
        tests++; if (stall_mem !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL alu_no_stall: stall %0b req %0b want 0 0", stall_mem, bus.mem_req); end
        tests++; if (fwd_mem !== 16'h1234) begin fails++; $display("FAIL alu_fwd: got %h want 1234", fwd_mem); end
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b1 || rd_wb !== 4'd5 || wbdata_wb !== 16'h1234) begin fails++; $display("FAIL alu_wb: got %0b %0d %h want 1 5 1234", regwrt_wb, rd_wb, wbdata_wb); end
        @(negedge clk); clear_ex();
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b0) begin fails++; $display("FAIL alu_idle_regwrt: got %0b want 0", regwrt_wb); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drive_op(0, 0, 1, 4'd1, 16'h1111, 16'h0);
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b1 || rd_wb !== 4'd1 || wbdata_wb !== 16'h1111) begin fails++; $display("FAIL b2b_first: got %0b %0d %h want 1 1 1111", regwrt_wb, rd_wb, wbdata_wb); end
        @(negedge clk); drive_op(0, 0, 1, 4'd2, 16'h2222, 16'h0);
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b1 || rd_wb !== 4'd2 || wbdata_wb !== 16'h2222) begin fails++; $display("FAIL b2b_second: got %0b %0d %h want 1 2 2222", regwrt_wb, rd_wb, wbdata_wb); end
        @(negedge clk); clear_ex();
    endtask

    task automatic test_load_wait();
        @(negedge clk); drive_op(1, 0, 1, 4'd7, 16'h0040, 16'h0); bus.mem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0040) begin fails++; $display("FAIL load_req_%0d: req %0b we %0b addr %h want 1 0 0040", i, bus.mem_req, bus.mem_we, bus.mem_addr); end
            tests++; if (stall_mem !== 1'b1) begin fails++; $display("FAIL load_stall_%0d: got %0b want 1", i, stall_mem); end
            @(posedge clk); #1;
            tests++; if (regwrt_wb !== 1'b0 || dbgState !== WAIT) begin fails++; $display("FAIL load_bubble_%0d: regwrt %0b state %0d want 0 WAIT", i, regwrt_wb, dbgState); end
            @(negedge clk);
        end
        bus.mem_ack = 1; bus.mem_rdata = 16'hBEEF;
        #1;
        tests++; if (stall_mem !== 1'b0 || bus.mem_req !== 1'b1) begin fails++; $display("FAIL load_ack_cycle: stall %0b req %0b want 0 1", stall_mem, bus.mem_req); end
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b1 || rd_wb !== 4'd7 || wbdata_wb !== 16'hBEEF) begin fails++; $display("FAIL load_wb: got %0b %0d %h want 1 7 beef", regwrt_wb, rd_wb, wbdata_wb); end
        tests++; if (dbgState !== IDLE) begin fails++; $display("FAIL load_back_idle: got %0d want IDLE", dbgState); end
        @(negedge clk); clear_ex(); bus.mem_ack = 0;
    endtask

    task automatic test_load_zero_wait();
        @(negedge clk); drive_op(1, 0, 1, 4'd9, 16'h0200, 16'h0); bus.mem_ack = 1; bus.mem_rdata = 16'h5A5A;
        #1;
        tests++; if (stall_mem !== 1'b0 || bus.mem_req !== 1'b1) begin fails++; $display("FAIL load0_req: stall %0b req %0b want 0 1", stall_mem, bus.mem_req); end
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b1 || rd_wb !== 4'd9 || wbdata_wb !== 16'h5A5A) begin fails++; $display("FAIL load0_wb: got %0b %0d %h want 1 9 5a5a", regwrt_wb, rd_wb, wbdata_wb); end
        @(negedge clk); clear_ex(); bus.mem_ack = 0;
    endtask

    task automatic test_store();
        @(negedge clk); drive_op(0, 1, 0, 4'd0, 16'h0010, 16'hA5A5); bus.mem_ack = 1;
        #1;
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin fails++; $display("FAIL store_req: req %0b we %0b want 1 1", bus.mem_req, bus.mem_we); end
        tests++; if (bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'hA5A5) begin fails++; $display("FAIL store_bus: addr %h data %h want 0010 a5a5", bus.mem_addr, bus.mem_wdata); end
        tests++; if (stall_mem !== 1'b0) begin fails++; $display("FAIL store_stall: got %0b want 0", stall_mem); end
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b0 || dbgState !== IDLE) begin fails++; $display("FAIL store_wb: regwrt %0b state %0d want 0 IDLE", regwrt_wb, dbgState); end
        @(negedge clk); clear_ex(); bus.mem_ack = 0;
    endtask

    task automatic test_spurious_ack();
        @(negedge clk); clear_ex(); bus.mem_ack = 1; bus.mem_rdata = 16'hDEAD;
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL spurious_req: req %0b stall %0b want 0 0", bus.mem_req, stall_mem); end
        @(posedge clk); #1;
        tests++; if (dbgState !== IDLE || regwrt_wb !== 1'b0) begin fails++; $display("FAIL spurious_state: state %0d regwrt %0b want IDLE 0", dbgState, regwrt_wb); end
        @(negedge clk); bus.mem_ack = 0;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); drive_op(1, 0, 1, 4'd4, 16'h0080, 16'h0); bus.mem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (dbgState !== WAIT || stall_mem !== 1'b1) begin fails++; $display("FAIL rstwait_pre: state %0d stall %0b want WAIT 1", dbgState, stall_mem); end
        @(negedge clk); #2; rst_n = 0; bus.mem_ack = 1;
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall_mem !== 1'b0 || regwrt_wb !== 1'b0) begin fails++; $display("FAIL rstwait_drop: req %0b stall %0b regwrt %0b want 0 0 0", bus.mem_req, stall_mem, regwrt_wb); end
        tests++; if (dbgState !== IDLE || fwd_mem !== 16'h0) begin fails++; $display("FAIL rstwait_state: state %0d fwd %h want IDLE 0000", dbgState, fwd_mem); end
        @(posedge clk); #1;
        tests++; if (dbgState !== IDLE || regwrt_wb !== 1'b0) begin fails++; $display("FAIL rstwait_ack_ignored: state %0d regwrt %0b want IDLE 0", dbgState, regwrt_wb); end
        @(negedge clk); rst_n = 1; bus.mem_ack = 0; drive_op(1, 0, 1, 4'd6, 16'h00C0, 16'h0);
        #1;
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h00C0 || stall_mem !== 1'b1) begin fails++; $display("FAIL rstwait_new_req: req %0b addr %h stall %0b want 1 00c0 1", bus.mem_req, bus.mem_addr, stall_mem); end
        @(negedge clk); bus.mem_ack = 1; bus.mem_rdata = 16'h1357;
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b1 || rd_wb !== 4'd6 || wbdata_wb !== 16'h1357) begin fails++; $display("FAIL rstwait_new_wb: got %0b %0d %h want 1 6 1357", regwrt_wb, rd_wb, wbdata_wb); end
        @(negedge clk); clear_ex(); bus.mem_ack = 0;
    endtask

    task automatic test_timeout();
        @(negedge clk); drive_op(1, 0, 1, 4'd2, 16'h0100, 16'h0); bus.mem_ack = 0;
        repeat (255) @(posedge clk);
        #1;
        tests++; if (mem_err !== 1'b0 || stall_mem !== 1'b1) begin fails++; $display("FAIL timeout_before: err %0b stall %0b want 0 1", mem_err, stall_mem); end
        @(posedge clk); #1;
        tests++; if (mem_err !== 1'b1 || stall_mem !== 1'b1 || dbgState !== WAIT) begin fails++; $display("FAIL timeout_set: err %0b stall %0b state %0d want 1 1 WAIT", mem_err, stall_mem, dbgState); end
        repeat (5) @(posedge clk);
        #1;
        tests++; if (mem_err !== 1'b1 || stall_mem !== 1'b1) begin fails++; $display("FAIL timeout_hold: err %0b stall %0b want 1 1", mem_err, stall_mem); end
        @(negedge clk); bus.mem_ack = 1; bus.mem_rdata = 16'h4242;
        @(posedge clk); #1;
        tests++; if (mem_err !== 1'b1 || dbgState !== IDLE || wbdata_wb !== 16'h4242) begin fails++; $display("FAIL timeout_sticky: err %0b state %0d data %h want 1 IDLE 4242", mem_err, dbgState, wbdata_wb); end
        @(negedge clk); clear_ex(); bus.mem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL timeout_idle_sticky: got %0b want 1", mem_err); end
        @(negedge clk); rst_n = 0;
        #1;
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL timeout_reset_clear: got %0b want 0", mem_err); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_halt();
        @(negedge clk); clear_ex(); valid_ex = 1; hlt_ex = 1;
        @(posedge clk); #1;
        tests++; if (hlt_wb !== 1'b1 || regwrt_wb !== 1'b0) begin fails++; $display("FAIL halt_set: hlt %0b regwrt %0b want 1 0", hlt_wb, regwrt_wb); end
        @(negedge clk); drive_op(0, 0, 1, 4'd3, 16'h3333, 16'h0);
        @(posedge clk); #1;
        tests++; if (regwrt_wb !== 1'b0 || hlt_wb !== 1'b1) begin fails++; $display("FAIL halt_suppress: regwrt %0b hlt %0b want 0 1", regwrt_wb, hlt_wb); end
        @(negedge clk); drive_op(1, 0, 1, 4'd8, 16'h0050, 16'h0); bus.mem_ack = 0;
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL halt_no_req: req %0b stall %0b want 0 0", bus.mem_req, stall_mem); end
        @(posedge clk); #1;
        tests++; if (hlt_wb !== 1'b1 || dbgState !== IDLE || regwrt_wb !== 1'b0) begin fails++; $display("FAIL halt_sticky: hlt %0b state %0d regwrt %0b want 1 IDLE 0", hlt_wb, dbgState, regwrt_wb); end
        @(negedge clk); clear_ex();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_wait();
        test_load_zero_wait();
        test_store();
        test_spurious_ack();
        test_reset_mid_wait();
        test_timeout();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
